tweet_buffer_ctrl: RTL and testbench
====================================

// Module: tweet_buffer_ctrl
// PURPOSE
//  Parametrised successor of the single-message UART tweet board. Receives async serial
//  bytes, stores them in an internal message buffer (DEPTH entries) with backspace
//  editing, and replays the message through a valid/ready byte interface to the UART TX
//  serializer. Also drives a serial echo path that is gated by buffer capacity.
//  Sits between the pin-level debouncers/serial input and the cereal TX block.
// PARAMETERS
//  CLK_HZ     50_000_000  sysclk frequency
//  BAUD       9600        serial bit rate; BIT_TICKS = CLK_HZ/BAUD, HALF = BIT_TICKS/2
//  DATA_BITS  8           bits per character, LSB first
//  DEPTH      160         message capacity in characters
//  ADDR_W     8           pointer/count width; must satisfy 2**ADDR_W > DEPTH
//  BS_CODE    8'h08       character treated as backspace
// PORTS
//  sysclk     in   1          system clock, all logic on posedge
//  reset_n    in   1          synchronous reset, active-low
//  active     in   1          block enable; 0 freezes RX FSM in IDLE and stalls playback
//  serial_in  in   1          async UART line, idle high
//  play       in   1          debounced 1-cycle pulse: start replay of stored message
//  clear      in   1          debounced 1-cycle pulse: discard stored message
//  tx_data    out  DATA_BITS  character to TX serializer
//  tx_valid   out  1          tx_data valid; held until tx_ready
//  tx_ready   in   1          TX serializer accepts tx_data this cycle
//  echo_out   out  1          serial_in when active && !full, else 1 (idle)
//  count      out  ADDR_W     characters currently stored
//  full       out  1          count == DEPTH
//  busy       out  1          playback in progress
//  frame_err  out  1          1-cycle pulse: stop bit sampled low, byte dropped
//  rx_drop    out  1          1-cycle pulse: valid byte dropped (full or busy)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): count=0, rd_ptr=0, both FSMs idle, tx_valid=0,
//   tx_data=0, busy=0, full=0, frame_err=0, rx_drop=0. Memory contents not wiped;
//   count alone defines validity. Reset mid-frame/mid-replay aborts immediately.
//  serial_in passes a 2-flop synchroniser before any use (2-cycle latency).
//  RX FSM: IDLE -> START on sync'd falling edge. START: wait HALF ticks; line 0 -> DATA,
//   line 1 -> IDLE (glitch, no pulse). DATA: sample every BIT_TICKS, shift LSB first,
//   after DATA_BITS samples -> STOP. STOP: sample after BIT_TICKS; 1 -> byte_done pulse,
//   0 -> frame_err pulse; both -> IDLE. Bit-tick counter resets on every state entry.
//  Store on byte_done (same cycle): busy=1 -> drop, rx_drop. byte==BS_CODE: count>0 ->
//   count-1, else no-op (no pulse). Other byte: count<DEPTH -> mem[count]=byte, count+1;
//   count==DEPTH -> drop, rx_drop. Backspace on full buffer is accepted.
//  clear: count<=0 when busy=0; ignored when busy=1. clear and byte_done same cycle:
//   clear wins, byte discarded silently.
//  Playback FSM P_IDLE/P_READ/P_SEND: play && count>0 && !busy -> P_READ, rd_ptr=0,
//   busy=1; play with count==0 ignored. P_READ: synchronous mem read (1 cycle) ->
//   P_SEND with tx_data loaded, tx_valid=1. P_SEND: tx_valid && tx_ready -> rd_ptr+1;
//   rd_ptr+1==count -> P_IDLE, tx_valid=0, busy=0; else -> P_READ. First tx_valid at
//   2 cycles after play. tx_data stable while tx_valid && !tx_ready. play during busy
//   ignored. Message retained after replay (replayable).
//  active=0: RX returns to IDLE (partial frame discarded); playback holds state and
//   tx_valid; echo_out=1. count/mem unaffected.
//  full and echo gating update in the cycle after count changes.
//  All counters width-exact; BIT_TICKS counter width = $clog2(BIT_TICKS)+1; no wrap paths.
// STRUCTURE
//  Shared package tweet_pkg: BS_CODE default, RX and playback state encodings.
//  One sub-module: uart_rx_core (sync, RX FSM, bit timing; outputs byte, byte_done,
//   frame_err). Buffer memory inferred as sync-read RAM inside top.
// TESTING
//  Send "HI" at BAUD -> count=2, full=0; play -> tx_data 8'h48 then 8'h49, busy drops.
//  Send "AB",BS,"C" -> count=2; replay emits 8'h41,8'h43. BS with count=0 -> count=0.
//  Send DEPTH+1 chars -> full=1 at DEPTH, one rx_drop pulse, echo_out held 1.
//  Frame with stop bit 0 -> frame_err pulse, count unchanged; 0.25-bit low glitch ignored.
//  Replay with tx_ready low 10 cycles per byte -> tx_data stable, no skip/duplicate;
//   play/clear during busy ignored; byte received during busy -> rx_drop.
//  reset_n low mid-frame and mid-replay -> all outputs at reset values next cycle, count=0.

Source files
------------

// File: rtl/tweet_pkg.sv
// Shared types and constants for the tweet buffer controller and its UART receiver.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package tweet_pkg;

  // Character that deletes the most recently stored character.
  localparam logic [7:0] BS_CODE_DEF = 8'h08;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_READ,
    P_SEND
  } play_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// Async serial receiver: 2-flop synchroniser, start-bit qualification, LSB-first data, stop check.
// Latency: byte_done pulses about half a bit after the stop bit begins (plus 2-cycle sync delay).
// Backpressure: none; byte_done/frame_err are single-cycle pulses the consumer must take or lose.
module uart_rx_core
  import tweet_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 sysclk,
  input  logic                 reset_n,
  input  logic                 active,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 byte_done,
  output logic                 frame_err
);

  localparam int BIT_TICKS = CLK_HZ / BAUD;
  localparam int HALF      = BIT_TICKS / 2;
  localparam int TICK_W    = $clog2(BIT_TICKS) + 1;
  localparam int BIT_W     = $clog2(DATA_BITS) + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(HALF - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 sync1, sync2, line_d;
  logic                 line_fall;
  rx_state_t            state;
  logic [TICK_W-1:0]    tick;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  // Bring the async line into the clock domain; line_d keeps the previous value for edge detection.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_d <= 1'b1;
    end else begin
      sync1  <= serial_in;
      sync2  <= sync1;
      line_d <= sync2;
    end
  end

  assign line_fall = line_d & ~sync2;

  // Frame FSM: the tick counter restarts on every state entry so each sample lands mid-bit.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state     <= RX_IDLE;
      tick      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      if (!active) begin
        state <= RX_IDLE;
        tick  <= '0;
      end else begin
        case (state)
          RX_IDLE: begin
            if (line_fall) begin
              state <= RX_START;
              tick  <= '0;
            end
          end
          RX_START: begin
            if (tick == HALF_LAST) begin
              tick    <= '0;
              bit_cnt <= '0;
              // A line already back high at mid start bit was only a glitch.
              state   <= sync2 ? RX_IDLE : RX_DATA;
            end else begin
              tick <= tick + 1'b1;
            end
          end
          RX_DATA: begin
            if (tick == TICK_LAST) begin
              tick  <= '0;
              shreg <= {sync2, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                state <= RX_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
          RX_STOP: begin
            if (tick == TICK_LAST) begin
              tick  <= '0;
              state <= RX_IDLE;
              if (sync2) begin
                rx_byte   <= shreg;
                byte_done <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/tweet_buffer_ctrl.sv
// Message buffer with backspace editing, replayed over a valid/ready byte port; gated serial echo.
// Latency: stored the cycle after byte_done; first tx_valid 2 cycles after play, 1 bubble per byte.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; RX bytes arriving during replay are dropped.
module tweet_buffer_ctrl
  import tweet_pkg::*;
#(
  parameter int                   CLK_HZ    = 50_000_000,
  parameter int                   BAUD      = 9600,
  parameter int                   DATA_BITS = 8,
  parameter int                   DEPTH     = 160,
  parameter int                   ADDR_W    = 8,
  parameter logic [DATA_BITS-1:0] BS_CODE   = BS_CODE_DEF
) (
  input  logic                 sysclk,
  input  logic                 reset_n,
  input  logic                 active,
  input  logic                 serial_in,
  input  logic                 play,
  input  logic                 clear,
  output logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 echo_out,
  output logic [ADDR_W-1:0]    count,
  output logic                 full,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 rx_drop
);

  localparam int                MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(DEPTH);

  logic [DATA_BITS-1:0] rx_byte;
  logic                 byte_done;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]    rd_ptr;
  logic [ADDR_W-1:0]    rd_ptr_nxt;
  play_state_t          pstate;
  logic                 clr_ok, wr_en, bs_ok, drop_now;

  uart_rx_core #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (DATA_BITS)
  ) u_rx (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .active    (active),
    .serial_in (serial_in),
    .rx_byte   (rx_byte),
    .byte_done (byte_done),
    .frame_err (frame_err)
  );

  // Decide what a received byte does; clear outranks a same-cycle byte and the byte vanishes silently.
  always_comb begin
    clr_ok   = clear && !busy;
    wr_en    = 1'b0;
    bs_ok    = 1'b0;
    drop_now = 1'b0;
    if (byte_done && !clr_ok) begin
      if (busy) begin
        drop_now = 1'b1;
      end else if (rx_byte == BS_CODE) begin
        bs_ok = (count != '0);
      end else if (count < DEPTH_C) begin
        wr_en = 1'b1;
      end else begin
        drop_now = 1'b1;
      end
    end
  end

  // Fill level; full and the echo gate follow count one cycle later.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      count   <= '0;
      full    <= 1'b0;
      rx_drop <= 1'b0;
    end else begin
      rx_drop <= drop_now;
      full    <= (count == DEPTH_C);
      if (clr_ok) begin
        count <= '0;
      end else if (wr_en) begin
        count <= count + 1'b1;
      end else if (bs_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  // Buffer write port; contents survive reset since count alone marks validity.
  always_ff @(posedge sysclk) begin
    if (wr_en) begin
      mem[count[MEM_AW-1:0]] <= rx_byte;
    end
  end

  assign rd_ptr_nxt = rd_ptr + 1'b1;

  // Replay FSM: sync-read each byte into tx_data, then hold it until the serializer takes it.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      pstate   <= P_IDLE;
      rd_ptr   <= '0;
      busy     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (active) begin
      case (pstate)
        P_IDLE: begin
          if (play && (count != '0)) begin
            pstate <= P_READ;
            rd_ptr <= '0;
            busy   <= 1'b1;
          end
        end
        P_READ: begin
          tx_data  <= mem[rd_ptr[MEM_AW-1:0]];
          tx_valid <= 1'b1;
          pstate   <= P_SEND;
        end
        P_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (rd_ptr_nxt == count) begin
              pstate <= P_IDLE;
              busy   <= 1'b0;
            end else begin
              rd_ptr <= rd_ptr_nxt;
              pstate <= P_READ;
            end
          end
        end
        default: pstate <= P_IDLE;
      endcase
    end
  end

  assign echo_out = (active && !full) ? serial_in : 1'b1;

endmodule

// File: tb/tb_tweet_buffer_ctrl.sv
module tb_tweet_buffer_ctrl;

  localparam int BT    = 8;   // clocks per serial bit (CLK_HZ/BAUD below)
  localparam int DEPTH = 8;

  logic       sysclk = 1'b0;
  logic       reset_n, active, serial_in, play, clear, tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, echo_out, full, busy, frame_err, rx_drop;
  logic [3:0] count;

  tweet_buffer_ctrl #(
    .CLK_HZ(16), .BAUD(2), .DATA_BITS(8), .DEPTH(DEPTH), .ADDR_W(4), .BS_CODE(8'h08)
  ) dut (
    .sysclk(sysclk), .reset_n(reset_n), .active(active), .serial_in(serial_in),
    .play(play), .clear(clear), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .echo_out(echo_out), .count(count), .full(full),
    .busy(busy), .frame_err(frame_err), .rx_drop(rx_drop)
  );

  always #5 sysclk = ~sysclk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expq[$];
  int         fe_cnt = 0, drop_cnt = 0, echo_low = 0;
  bit         echo_watch = 0, mon_en = 0;
  int         stall_len = 0;
  bit         hold_prev = 0;
  logic [7:0] hold_dat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Serializer model: tx_ready low for stall_len cycles of each tx_valid, then one accept cycle.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    tx_ready = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      if (tx_valid) begin
        if (wait_cnt >= stall_len) begin
          tx_ready = 1'b1;
          wait_cnt = 0;
        end else begin
          tx_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        tx_ready = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pulse counters, echo watch, scoreboard pop on each handshake, hold-stability check.
  always @(negedge sysclk) begin
    if (frame_err) fe_cnt++;
    if (rx_drop) drop_cnt++;
    if (echo_watch && !echo_out) echo_low++;
    if (mon_en) begin
      if (hold_prev) begin
        check("tx_hold_valid", tx_valid, 1);
        check("tx_hold_data", tx_data, hold_dat);
      end
      if (tx_valid && tx_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected actual=%0h expected=none", tx_data);
        end else begin
          check("tx_byte", tx_data, expq.pop_front());
        end
      end
      hold_prev = tx_valid && !tx_ready;
      hold_dat  = tx_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // All stimulus tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    repeat (BT) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (BT) @(negedge sysclk);
    end
    serial_in = stop_bit;
    repeat (BT) @(negedge sysclk);
    serial_in = 1'b1;
    repeat (BT) @(negedge sysclk);
  endtask

  task automatic play_pulse();
    play = 1'b1;
    @(negedge sysclk);
    play = 1'b0;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(negedge sysclk);
    clear = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge sysclk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s actual=busy expected=idle within 3000 cycles", name);
    end
    @(negedge sysclk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0;
    reset_n   = 1'b0;
    active    = 1'b1;
    serial_in = 1'b1;
    play      = 1'b0;
    clear     = 1'b0;
    repeat (3) @(negedge sysclk);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rx_drop", rx_drop, 0);
    check("rst_echo", echo_out, 1);
    reset_n = 1'b1;
    @(negedge sysclk);
    mon_en = 1'b1;

    // "HI" then replay, checking first-valid latency
    send_byte(8'h48, 1'b1);
    send_byte(8'h49, 1'b1);
    repeat (2) @(negedge sysclk);
    check("hi_count", count, 2);
    check("hi_full", full, 0);
    expq.push_back(8'h48);
    expq.push_back(8'h49);
    play_pulse();
    check("hi_valid_cycle1", tx_valid, 0);
    check("hi_busy", busy, 1);
    @(negedge sysclk);
    check("hi_valid_cycle2", tx_valid, 1);
    check("hi_first_data", tx_data, 8'h48);
    wait_idle("hi_idle");
    check("hi_drain", expq.size(), 0);
    check("hi_retained", count, 2);

    // "AB", backspace, "C"
    clear_pulse();
    check("clear_count", count, 0);
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h43, 1'b1);
    check("bs_count", count, 2);
    expq.push_back(8'h41);
    expq.push_back(8'h43);
    play_pulse();
    wait_idle("bs_idle");
    check("bs_drain", expq.size(), 0);

    // backspace on empty buffer
    clear_pulse();
    d0 = drop_cnt;
    send_byte(8'h08, 1'b1);
    check("bs_empty_count", count, 0);
    check("bs_empty_nodrop", drop_cnt - d0, 0);

    // fill to DEPTH, overflow by one, then backspace on full
    for (int i = 0; i < DEPTH; i++) send_byte(8'h61 + 8'(i), 1'b1);
    check("fill_count", count, DEPTH);
    check("fill_full", full, 1);
    check("fill_nodrop", drop_cnt - d0, 0);
    echo_low   = 0;
    echo_watch = 1'b1;
    send_byte(8'h69, 1'b1);
    echo_watch = 1'b0;
    check("ovf_count", count, DEPTH);
    check("ovf_drop", drop_cnt - d0, 1);
    check("ovf_echo_held", echo_low, 0);
    send_byte(8'h08, 1'b1);
    check("bs_full_count", count, DEPTH - 1);
    check("bs_full_flag", full, 0);
    for (int i = 0; i < DEPTH - 1; i++) expq.push_back(8'h61 + 8'(i));
    play_pulse();
    wait_idle("fill_idle");
    check("fill_drain", expq.size(), 0);

    // bad stop bit, then a quarter-bit glitch
    clear_pulse();
    f0 = fe_cnt;
    send_byte(8'h55, 1'b0);
    check("ferr_pulse", fe_cnt - f0, 1);
    check("ferr_count", count, 0);
    serial_in = 1'b0;
    repeat (BT / 4) @(negedge sysclk);
    serial_in = 1'b1;
    repeat (100) @(negedge sysclk);
    check("glitch_count", count, 0);
    check("glitch_nopulse", fe_cnt - f0, 1);

    // inactive: receiver ignores the line and echo is idle
    active     = 1'b0;
    echo_low   = 0;
    echo_watch = 1'b1;
    send_byte(8'h4d, 1'b1);
    echo_watch = 1'b0;
    active     = 1'b1;
    @(negedge sysclk);
    check("inactive_count", count, 0);
    check("inactive_echo", echo_low, 0);

    // stalled replay with play, clear and a received byte all during busy
    send_byte(8'h57, 1'b1);
    send_byte(8'h58, 1'b1);
    send_byte(8'h59, 1'b1);
    send_byte(8'h5a, 1'b1);
    check("stall_count", count, 4);
    stall_len = 10;
    for (int i = 0; i < 4; i++) expq.push_back(8'h57 + 8'(i));
    d0 = drop_cnt;
    fork
      send_byte(8'h51, 1'b1);
      begin
        repeat (45) @(negedge sysclk);
        play_pulse();
        repeat (10) @(negedge sysclk);
        play_pulse();
        repeat (5) @(negedge sysclk);
        clear = 1'b1;
        @(negedge sysclk);
        clear = 1'b0;
      end
    join
    wait_idle("stall_idle");
    check("stall_drain", expq.size(), 0);
    check("busy_drop", drop_cnt - d0, 1);
    check("busy_clear_ignored", count, 4);
    stall_len = 0;
    for (int i = 0; i < 4; i++) expq.push_back(8'h57 + 8'(i));
    play_pulse();
    wait_idle("replay_idle");
    check("replay_drain", expq.size(), 0);

    // reset mid-frame
    f0 = fe_cnt;
    fork
      send_byte(8'h52, 1'b1);
      begin
        repeat (30) @(negedge sysclk);
        mon_en = 1'b0;
        @(negedge sysclk);
        reset_n = 1'b0;
        @(negedge sysclk);
        check("rstf_count", count, 0);
        check("rstf_busy", busy, 0);
        check("rstf_tx_valid", tx_valid, 0);
      end
    join
    reset_n = 1'b1;
    repeat (3) @(negedge sysclk);
    mon_en = 1'b1;
    check("rstf_aborted", count, 0);
    check("rstf_noferr", fe_cnt - f0, 0);
    send_byte(8'h4b, 1'b1);
    send_byte(8'h4c, 1'b1);
    check("rstf_rx_ok", count, 2);

    // reset mid-replay
    stall_len = 10;
    expq.push_back(8'h4b);
    expq.push_back(8'h4c);
    play_pulse();
    repeat (5) @(negedge sysclk);
    check("rstp_loaded", tx_data, 8'h4b);
    mon_en = 1'b0;
    @(negedge sysclk);
    reset_n = 1'b0;
    @(negedge sysclk);
    check("rstp_busy", busy, 0);
    check("rstp_tx_valid", tx_valid, 0);
    check("rstp_tx_data", tx_data, 0);
    check("rstp_count", count, 0);
    check("rstp_rx_drop", rx_drop, 0);
    expq.delete();
    reset_n   = 1'b1;
    stall_len = 0;
    repeat (2) @(negedge sysclk);
    check("rstp_idle_after", busy, 0);

    check("final_queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
